// File: rtl/flash_loader.sv
// UART bootloader write side: frames bytes into 16-bit flash words.
// Optional trailing checksum byte when LOADER_CKSUM_EN is defined.
module flash_loader #(
    parameter int unsigned flash_width    = 10,
    parameter logic [7:0]  sync_byte      = 8'hA5,
    parameter int unsigned timeout_cycles = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   mem_we,
    output logic [flash_width-1:0] mem_a,
    output logic [15:0]            mem_d,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int unsigned CW = $clog2(timeout_cycles + 1);
    localparam logic [16:0] CAP = 17'(2 ** flash_width);
    localparam logic [CW-1:0] TLAST = CW'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_CKSUM,
        S_ERROR
    } state_t;

    state_t state, state_n;
    logic [15:0]            len, len_n;
    logic [7:0]             lo, lo_n;
    logic [flash_width:0]   idx, idx_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   we_n, hold_n, done_n;
    logic [flash_width-1:0] a_n;
    logic [15:0]            d_n;
    logic [16:0]            nwords;
    logic                   in_frame;
`ifdef LOADER_CKSUM_EN
    logic [7:0]             sum, sum_n;
`endif

    assign nwords = 17'(idx) + 17'd1;
    assign in_frame = (state != S_IDLE) && (state != S_ERROR);

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len      <= '0;
            lo       <= '0;
            idx      <= '0;
            cnt      <= '0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_d    <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef LOADER_CKSUM_EN
            sum      <= '0;
`endif
        end else begin
            state    <= state_n;
            len      <= len_n;
            lo       <= lo_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            mem_we   <= we_n;
            mem_a    <= a_n;
            mem_d    <= d_n;
            cpu_hold <= hold_n;
            busy     <= (state_n != S_IDLE) && (state_n != S_ERROR);
            done     <= done_n;
            error    <= (state_n == S_ERROR);
`ifdef LOADER_CKSUM_EN
            sum      <= sum_n;
`endif
        end
    end

    // Frame parsing, word packing and inter-byte timeout
    always_comb begin
        state_n = state;
        len_n   = len;
        lo_n    = lo;
        idx_n   = idx;
        cnt_n   = '0;
        we_n    = 1'b0;
        a_n     = mem_a;
        d_n     = mem_d;
        hold_n  = cpu_hold;
        done_n  = 1'b0;
`ifdef LOADER_CKSUM_EN
        sum_n   = sum;
`endif
        if (in_frame && !rx_valid) begin
            cnt_n = cnt + 1'b1;
        end
        if (rx_valid) begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (rx_data == sync_byte) begin
                        state_n = S_LEN_LO;
                        hold_n  = 1'b1;
                        idx_n   = '0;
`ifdef LOADER_CKSUM_EN
                        sum_n   = '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    len_n   = {len[15:8], rx_data};
                    state_n = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_n = {rx_data, len[7:0]};
                    if ({1'b0, len_n} > CAP) begin
                        state_n = S_ERROR;
                    end else if (len_n == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                        state_n = S_CKSUM;
`else
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
`endif
                    end else begin
                        state_n = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    lo_n    = rx_data;
                    state_n = S_DATA_HI;
`ifdef LOADER_CKSUM_EN
                    sum_n   = sum + rx_data;
`endif
                end
                S_DATA_HI: begin
                    we_n  = 1'b1;
                    a_n   = idx[flash_width-1:0];
                    d_n   = {rx_data, lo};
                    idx_n = idx + 1'b1;
`ifdef LOADER_CKSUM_EN
                    sum_n = sum + rx_data;
`endif
                    if (nwords == {1'b0, len}) begin
`ifdef LOADER_CKSUM_EN
                        state_n = S_CKSUM;
`else
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
`endif
                    end else begin
                        state_n = S_DATA_LO;
                    end
                end
`ifdef LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (rx_data == sum) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        hold_n  = 1'b0;
                    end else begin
                        state_n = S_ERROR;
                    end
                end
`endif
                default: ;
            endcase
        end else if (in_frame && cnt == TLAST) begin
            state_n = S_ERROR;
            cnt_n   = '0;
        end
    end

endmodule
